dmux_router: RTL and testbench
==============================

DMUX_ROUTER -- requirements
Module: dmux_router

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter NCH, default 8, meaning output channel count (2..16).
REQ-003 The block SHALL have parameter SELW, default 3, meaning select width; NCH SHALL be at most 2**SELW.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-009 The block SHALL have port in_sel, input, SELW bits: destination channel index.
REQ-010 The block SHALL have port in_bcast, input, 1 bit: deliver the word to every channel and ignore in_sel.
REQ-011 The block SHALL have port out_valid, output, NCH bits: per-channel word held.
REQ-012 The block SHALL have port out_ready, input, NCH bits: per-channel downstream accept.
REQ-013 The block SHALL have port out_data, output, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: count of words dropped for out-of-range select.

Function
REQ-015 Per channel k, the block SHALL hold a one-word output register with valid flag out_valid[k]; free(k) = !out_valid[k] || out_ready[k].
REQ-016 A unicast word (in_bcast=0, in_sel<NCH) SHALL set in_ready = free(in_sel).
REQ-017 A broadcast word (in_bcast=1) SHALL set in_ready = AND of free(k) over all k, so the transfer is all-or-nothing.
REQ-018 A word with in_bcast=0 and in_sel>=NCH SHALL set in_ready=1, the word SHALL be discarded, and drop_cnt SHALL increment by 1, saturating at 255.
REQ-019 When in_valid && in_ready, each targeted channel SHALL load in_data and set out_valid one cycle later (latency 1).
REQ-020 When out_valid[k] && out_ready[k] and channel k is not loaded in the same cycle, out_valid[k] SHALL clear next cycle.
REQ-021 A simultaneous drain and load on the same channel SHALL replace the word with no bubble, keeping out_valid[k]=1 so one word per cycle sustains.
REQ-022 in_ready SHALL be combinational from in_valid-independent inputs (in_sel, in_bcast, out_valid, out_ready) only and SHALL NOT depend on in_valid.
REQ-023 While out_valid[k]=1 and out_ready[k]=0, out_data for channel k SHALL remain stable.
REQ-024 Non-targeted channels SHALL retain their state on every transfer.
REQ-025 out_data of a channel with out_valid=0 SHALL hold its last value; its content is don't-care for the consumer.
REQ-026 Channel order SHALL be preserved per channel; no reordering or duplication except an explicit broadcast.

Reset
REQ-027 Asserting rst_n=0 SHALL asynchronously clear all out_valid bits, all out_data registers, and drop_cnt to 0.
REQ-028 A reset asserted mid-transfer SHALL discard held words; in_ready SHALL then equal 1 for any select.
REQ-029 After deassertion, the first transfer SHALL be accepted on the first rising clk edge with rst_n=1.

Verification
REQ-030 Unicast sweep: NCH=8, out_ready=8'hFF, in_sel steps 0..7 with in_data=16'h00A0+sel -> channel sel shows out_valid one cycle later with data 16'h00A0+sel, and all other channels stay idle.
REQ-031 Backpressure: load ch3 with 16'h1234, then out_ready[3]=0 and a second word 16'h5678 to ch3 -> in_ready=0, ch3 holds 16'h1234; raise out_ready[3] -> 16'h5678 loads the next cycle.
REQ-032 Broadcast: in_bcast=1, in_data=16'hBEEF, out_ready[5]=0 with ch5 full -> in_ready=0 and no channel changes; free ch5 -> all 8 channels show 16'hBEEF.
REQ-033 Throughput: continuous valid to ch0 with out_ready[0]=1 for 10 cycles -> 10 words delivered in order with no bubble.
REQ-034 Drop: NCH=6, in_sel=6 and 7 for 300 words total -> in_ready=1 throughout, no out_valid set, drop_cnt saturates at 255.
REQ-035 Async reset: assert rst_n=0 between clk edges while out_valid=8'h0F -> out_valid=0 and drop_cnt=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/dmux_router.sv
// -----------------------------------------------------------------------------
// dmux_router
//   Routes one upstream word per cycle to one of NCH output channels (unicast)
//   or to all of them at once (broadcast). Each channel owns a single-word
//   output register with a valid flag; a channel can accept a new word when it
//   is empty or is being drained in the same cycle, so a drain and a load on
//   the same channel sustain one word per cycle with no bubble.
//   Unicast words addressed beyond the last channel are accepted and discarded,
//   and counted in a saturating 8-bit drop counter.
//
// Parameters
//   WIDTH : data word width in bits
//   NCH   : number of output channels (2..16, and NCH <= 2**SELW)
//   SELW  : width of the channel select
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream word present
//   in_ready  : word accepted this cycle (does not depend on in_valid)
//   in_data   : upstream word
//   in_sel    : destination channel index (ignored when in_bcast=1)
//   in_bcast  : deliver the word to every channel, all-or-nothing
//   out_valid : per-channel word held
//   out_ready : per-channel downstream accept
//   out_data  : channel k occupies bits [k*WIDTH +: WIDTH]
//   drop_cnt  : words dropped for out-of-range select, saturates at 255
// -----------------------------------------------------------------------------
module dmux_router #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [7:0]           drop_cnt
);

    logic [NCH-1:0]            r_valid;
    logic [NCH-1:0][WIDTH-1:0] r_data;
    logic [7:0]                r_drop_cnt;

    logic [NCH-1:0] w_free;
    logic [NCH-1:0] w_sel_hit;
    logic [NCH-1:0] w_target;
    logic [NCH-1:0] w_load;
    logic           w_in_range;
    logic           w_in_ready;
    logic           w_drop;

    // A channel can take a word if it is empty or its current word leaves now.
    assign w_free = ~r_valid | out_ready;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_hit  = '0;
        w_target   = '0;
        w_in_ready = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            w_sel_hit[k] = (in_sel == SELW'(k));
        end
        // No hit means the select points past the last channel.
        w_in_range = |w_sel_hit;
        if (in_bcast) begin
            w_target   = '1;
            w_in_ready = &w_free;
        end else if (w_in_range) begin
            w_target   = w_sel_hit;
            w_in_ready = |(w_sel_hit & w_free);
        end
        w_drop = in_valid && !in_bcast && !w_in_range;
    end

    assign w_load = (in_valid && w_in_ready) ? w_target : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    // NOTE: the data registers are reset along with the valid flags so that
    // out_data is a known zero after reset, not just don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_load[k]) begin
                    // Load wins over drain: replacement keeps valid high.
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_dmux_router.sv
// -----------------------------------------------------------------------------
// tb_dmux_router
//   Directed bench for dmux_router. An 8-channel instance covers unicast,
//   backpressure, broadcast, throughput and async reset; a 6-channel instance
//   covers out-of-range drops and drop counter saturation.
//   Inputs change on the falling edge; in_ready is sampled 1 time unit later,
//   registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dmux_router;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;

    // 8-channel instance
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_sel;
    logic             in_bcast;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]       drop_cnt;

    // 6-channel instance
    logic             in6_valid;
    logic             in6_ready;
    logic [WIDTH-1:0] in6_data;
    logic [2:0]       in6_sel;
    logic             in6_bcast;
    logic [5:0]       out6_valid;
    logic [5:0]       out6_ready;
    logic [6*WIDTH-1:0] out6_data;
    logic [7:0]       drop6_cnt;

    int checks;
    int errors;

    dmux_router #(.WIDTH(WIDTH), .NCH(8), .SELW(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    dmux_router #(.WIDTH(WIDTH), .NCH(6), .SELW(3)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in6_valid),
        .in_ready  (in6_ready),
        .in_data   (in6_data),
        .in_sel    (in6_sel),
        .in_bcast  (in6_bcast),
        .out_valid (out6_valid),
        .out_ready (out6_ready),
        .out_data  (out6_data),
        .drop_cnt  (drop6_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch_data(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // Present a word on the 8-channel instance at the falling edge.
    task automatic drive(input logic v, input logic [2:0] sel, input logic b,
                         input logic [WIDTH-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sel   = sel;
        in_bcast = b;
        in_data  = d;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        in_bcast   = 1'b0;
        out_ready  = 8'h00;
        in6_valid  = 1'b0;
        in6_data   = '0;
        in6_sel    = '0;
        in6_bcast  = 1'b0;
        out6_ready = 6'h3F;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h00);
        check("rst_out_data",  32'(ch_data(0)), 32'h0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'h00);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- unicast sweep ----------------
        out_ready = 8'hFF;
        for (int s = 0; s < 8; s++) begin
            drive(1'b1, 3'(s), 1'b0, 16'h00A0 + 16'(s));
            #1;
            check($sformatf("sweep_ready_%0d", s), 32'(in_ready), 32'h1);
            after_edge();
            check($sformatf("sweep_valid_%0d", s), 32'(out_valid), 32'(8'h01 << s));
            check($sformatf("sweep_data_%0d", s), 32'(ch_data(s)), 32'h00A0 + s);
        end
        drive(1'b0, 3'd0, 1'b0, 16'h0);
        after_edge();
        check("sweep_drained", 32'(out_valid), 32'h00);

        // ---------------- backpressure on ch3 ----------------
        out_ready = 8'hF7;
        drive(1'b1, 3'd3, 1'b0, 16'h1234);
        after_edge();
        check("bp_first_valid", 32'(out_valid), 32'h08);
        check("bp_first_data",  32'(ch_data(3)), 32'h1234);
        drive(1'b1, 3'd3, 1'b0, 16'h5678);
        #1;
        check("bp_blocked_ready", 32'(in_ready), 32'h0);
        after_edge();
        check("bp_hold_valid", 32'(out_valid), 32'h08);
        check("bp_hold_data",  32'(ch_data(3)), 32'h1234);
        @(negedge clk);
        out_ready = 8'hFF;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        after_edge();
        check("bp_second_valid", 32'(out_valid), 32'h08);
        check("bp_second_data",  32'(ch_data(3)), 32'h5678);
        drive(1'b0, 3'd0, 1'b0, 16'h0);
        after_edge();
        check("bp_drained", 32'(out_valid), 32'h00);

        // ---------------- broadcast, all-or-nothing ----------------
        out_ready = 8'hDF;
        drive(1'b1, 3'd5, 1'b0, 16'h5555);
        after_edge();
        check("bc_ch5_full", 32'(out_valid), 32'h20);
        drive(1'b1, 3'd2, 1'b1, 16'hBEEF);
        #1;
        check("bc_blocked_ready", 32'(in_ready), 32'h0);
        after_edge();
        check("bc_blocked_valid", 32'(out_valid), 32'h20);
        check("bc_blocked_ch5",   32'(ch_data(5)), 32'h5555);
        check("bc_blocked_ch2",   32'(ch_data(2)), 32'h00A2);
        @(negedge clk);
        out_ready = 8'hFF;
        #1;
        check("bc_release_ready", 32'(in_ready), 32'h1);
        after_edge();
        check("bc_all_valid", 32'(out_valid), 32'hFF);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bc_data_%0d", k), 32'(ch_data(k)), 32'hBEEF);
        end
        drive(1'b0, 3'd0, 1'b0, 16'h0);
        after_edge();
        check("bc_drained", 32'(out_valid), 32'h00);

        // ---------------- throughput on ch0, no bubble ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd0, 1'b0, 16'h0100 + 16'(i));
            #1;
            check($sformatf("tp_ready_%0d", i), 32'(in_ready), 32'h1);
            after_edge();
            check($sformatf("tp_valid_%0d", i), 32'(out_valid), 32'h01);
            check($sformatf("tp_data_%0d", i), 32'(ch_data(0)), 32'h0100 + i);
        end
        drive(1'b0, 3'd0, 1'b0, 16'h0);
        after_edge();
        check("tp_drained", 32'(out_valid), 32'h00);

        // ---------------- drops on the 6-channel instance ----------------
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in6_valid = 1'b1;
            in6_sel   = (i % 2 == 0) ? 3'd6 : 3'd7;
            in6_data  = 16'(i);
            #1;
            check($sformatf("drop_ready_%0d", i), 32'(in6_ready), 32'h1);
            after_edge();
            if (i == 9) check("drop_cnt_10", 32'(drop6_cnt), 32'd10);
            if (i == 254) check("drop_cnt_255", 32'(drop6_cnt), 32'd255);
        end
        @(negedge clk);
        in6_valid = 1'b0;
        check("drop_no_valid", 32'(out6_valid), 32'h00);
        check("drop_saturated", 32'(drop6_cnt), 32'd255);

        // ---------------- async reset between edges ----------------
        out_ready = 8'h00;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 3'(s), 1'b0, 16'h0C00 + 16'(s));
            after_edge();
        end
        drive(1'b0, 3'd3, 1'b0, 16'h0);
        #1;
        check("ar_pre_valid", 32'(out_valid), 32'h0F);
        check("ar_pre_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("ar_valid_cleared", 32'(out_valid), 32'h00);
        check("ar_data_cleared",  32'(ch_data(2)), 32'h0);
        check("ar_drop_cleared",  32'(drop6_cnt), 32'h00);
        check("ar_ready_any_sel", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // first transfer after reset release is taken on the next edge
        out_ready = 8'hFF;
        drive(1'b1, 3'd6, 1'b0, 16'h0E06);
        after_edge();
        check("post_rst_valid", 32'(out_valid), 32'h40);
        check("post_rst_data",  32'(ch_data(6)), 32'h0E06);
        drive(1'b0, 3'd0, 1'b0, 16'h0);
        after_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
